// File: rtl/edge_event_tx.sv
// edge_event_tx: transmit end of the single-wire toggle event link.
// One-cycle event pulses on evt_in are queued in a saturating pending
// counter; each pending event is launched as exactly one transition on
// sig_a, with at least HOLD_CYC+1 clocks between transitions so the
// receiver's synchronizer plus any-edge detector fires once per event.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   evt_in   in   event request, each high cycle is one event
//   ovf_clr  in   clears the sticky overflow flag
//   sig_a    out  registered toggle line to the receiver
//   busy     out  HOLD in progress or events still pending
//   pend_cnt out  events accepted but not yet launched
//   ovf      out  sticky flag, an event was dropped
//
// HOLD_CYC must be >= 2.
module edge_event_tx #(
  parameter int unsigned HOLD_CYC = 3,
  parameter int unsigned CNT_W    = 4,
  parameter logic        INIT_LVL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             evt_in,
  input  logic             ovf_clr,
  output logic             sig_a,
  output logic             busy,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             ovf
);

  localparam int unsigned HC_W = $clog2(HOLD_CYC);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [HC_W-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             sig_a_q, sig_a_d;
  logic             ovf_q, ovf_d;

  logic launch;
  logic full;
  logic accept;
  logic drop;

  always_comb begin
    launch = (state_q == IDLE) && (pend_q != '0);
    full   = (pend_q == '1);
    // A launch in the same cycle frees a slot, so a full counter still accepts.
    accept = evt_in && (!full || launch);
    drop   = evt_in && full && !launch;
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    sig_a_d = sig_a_q;
    case (state_q)
      IDLE: begin
        if (launch) begin
          sig_a_d = ~sig_a_q;
          state_d = HOLD;
          hold_d  = HC_W'(HOLD_CYC - 1);
        end
      end
      HOLD: begin
        if (hold_q == '0) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q - HC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pend_d = pend_q;
    if (accept && !launch) begin
      pend_d = pend_q + CNT_W'(1);
    end else if (launch && !accept) begin
      pend_d = pend_q - CNT_W'(1);
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    // A new drop in the same cycle as a clear keeps the flag set.
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      pend_q  <= '0;
      sig_a_q <= INIT_LVL;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      sig_a_q <= sig_a_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sig_a    = sig_a_q;
  assign pend_cnt = pend_q;
  assign ovf      = ovf_q;
  assign busy     = (state_q == HOLD) || (pend_q != '0);

endmodule
